// File: rtl/shift_sub_divider.sv
// rtl/shift_sub_divider.sv - restoring shift-subtract divider; `SIGNED_DIV_EN adds two's-complement mode
module HexDriver (
    input  logic [3:0] In0,
    output logic [6:0] Out0
);
    // Active-low segments, bit 6 = g ... bit 0 = a
    always_comb begin
        case (In0)
            4'h0:    Out0 = 7'b1000000;
            4'h1:    Out0 = 7'b1111001;
            4'h2:    Out0 = 7'b0100100;
            4'h3:    Out0 = 7'b0110000;
            4'h4:    Out0 = 7'b0011001;
            4'h5:    Out0 = 7'b0010010;
            4'h6:    Out0 = 7'b0000010;
            4'h7:    Out0 = 7'b1111000;
            4'h8:    Out0 = 7'b0000000;
            4'h9:    Out0 = 7'b0010000;
            4'hA:    Out0 = 7'b0001000;
            4'hB:    Out0 = 7'b0000011;
            4'hC:    Out0 = 7'b1000110;
            4'hD:    Out0 = 7'b0100001;
            4'hE:    Out0 = 7'b0000110;
            default: Out0 = 7'b0001110;
        endcase
    end
endmodule

module shift_sub_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run_h,
    input  logic             ClearA_LoadB_h,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] QVal,
    output logic [WIDTH-1:0] RVal,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
`ifdef SIGNED_DIV_EN
    localparam logic [1:0] S_FIX  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic             run_sync_q, run_prev_q, load_sync_q;
    logic             run_edge;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   p, diff;
`ifdef SIGNED_DIV_EN
    logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic [WIDTH-1:0] din_mag, q_mag;
`endif

    assign run_edge = run_sync_q & ~run_prev_q;
    assign p        = {r_q, q_q[WIDTH-1]};
    assign diff     = p - {1'b0, d_q};

`ifdef SIGNED_DIV_EN
    assign din_mag = Din[WIDTH-1] ? -Din : Din;
    assign q_mag   = q_q[WIDTH-1] ? -q_q : q_q;
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
`ifdef SIGNED_DIV_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                // Load has priority; a simultaneous run edge is dropped
                if (load_sync_q) begin
                    q_d     = Din;
                    r_d     = '0;
                    dz_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (run_edge) begin
                    d_d   = Din;
                    cnt_d = '0;
                    if (Din == '0) begin
                        dz_d    = 1'b1;
                        q_d     = '1;
                        r_d     = q_q;
                        state_d = S_DONE;
                    end else begin
                        dz_d    = 1'b0;
                        r_d     = '0;
                        state_d = S_ITER;
`ifdef SIGNED_DIV_EN
                        d_d     = din_mag;
                        q_d     = q_mag;
                        neg_q_d = Din[WIDTH-1] ^ q_q[WIDTH-1];
                        neg_r_d = q_q[WIDTH-1];
`endif
                    end
                end
            end
            S_ITER: begin
                if (!diff[WIDTH]) begin
                    r_d = diff[WIDTH-1:0];
                end else begin
                    r_d = p[WIDTH-1:0];
                end
                q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIGNED_DIV_EN
                    state_d = S_FIX;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            S_FIX: begin
                // Truncation toward zero: remainder follows the dividend's sign
                if (neg_q_q) q_d = -q_q;
                if (neg_r_q) r_d = -r_q;
                state_d = S_DONE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            run_sync_q  <= 1'b0;
            run_prev_q  <= 1'b0;
            load_sync_q <= 1'b0;
            state_q     <= S_IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            run_sync_q  <= ~Run_h;
            run_prev_q  <= run_sync_q;
            load_sync_q <= ~ClearA_LoadB_h;
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            dz_q        <= dz_d;
`ifdef SIGNED_DIV_EN
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
`endif
        end
    end

    assign QVal    = q_q;
    assign RVal    = r_q;
    assign DivZero = dz_q;
    assign Done    = (state_q == S_DONE);
`ifdef SIGNED_DIV_EN
    assign Busy    = (state_q == S_ITER) || (state_q == S_FIX);
`else
    assign Busy    = (state_q == S_ITER);
`endif

    logic [7:0] q_hex, r_hex;
    generate
        if (WIDTH >= 8) begin : g_hex_wide
            assign q_hex = q_q[7:0];
            assign r_hex = r_q[7:0];
        end else begin : g_hex_narrow
            assign q_hex = {{(8 - WIDTH){1'b0}}, q_q};
            assign r_hex = {{(8 - WIDTH){1'b0}}, r_q};
        end
    endgenerate

    HexDriver u_hex0 (.In0(q_hex[3:0]),     .Out0(HEX0));
    HexDriver u_hex1 (.In0(q_hex[7:4]),     .Out0(HEX1));
    HexDriver u_hex2 (.In0(r_hex[3:0]),     .Out0(HEX2));
    HexDriver u_hex3 (.In0(r_hex[7:4]),     .Out0(HEX3));
    HexDriver u_hex4 (.In0({3'b000, dz_q}), .Out0(HEX4));
endmodule

// File: tb/tb_shift_sub_divider.sv
// tb/tb_shift_sub_divider.sv - bench for shift_sub_divider (unsigned, or signed with SIGNED_DIV_EN)
module tb_shift_sub_divider;
    localparam int W = 8;
`ifdef SIGNED_DIV_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 10;
`endif

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Run_h = 1'b1;
    logic         ClearA_LoadB_h = 1'b1;
    logic [W-1:0] Din = '0;
    logic [W-1:0] QVal, RVal;
    logic         Busy, Done, DivZero;
    logic [6:0]   HEX0, HEX1, HEX2, HEX3, HEX4;

    int n_assert = 0;
    int n_fail = 0;

    shift_sub_divider #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run_h(Run_h), .ClearA_LoadB_h(ClearA_LoadB_h),
        .Din(Din), .QVal(QVal), .RVal(RVal), .Busy(Busy), .Done(Done), .DivZero(DivZero),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: operation-level view of the divider (arithmetic quotient/remainder plus a busy countdown)
    bit         m_run_s, m_run_p, m_load_s, m_done, m_dz;
    logic [7:0] m_q = '0, m_r = '0, m_fin_q = '0, m_fin_r = '0;
    int         m_busy_left = 0;

    task automatic model_step();
        bit edge_seen;
        int a, b;
        if (!Reset_n) begin
            m_run_s = 0; m_run_p = 0; m_load_s = 0;
            m_q = '0; m_r = '0; m_done = 0; m_dz = 0; m_busy_left = 0;
            return;
        end
        edge_seen = m_run_s && !m_run_p;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_q = m_fin_q; m_r = m_fin_r; m_done = 1;
            end
        end else if (m_load_s) begin
            m_q = Din; m_r = '0; m_done = 0; m_dz = 0;
        end else if (edge_seen) begin
            if (Din == 0) begin
                m_dz = 1; m_r = m_q; m_q = 8'hFF; m_done = 1;
            end else begin
                m_dz = 0; m_done = 0;
`ifdef SIGNED_DIV_EN
                a = $signed(m_q); b = $signed(Din);
                if (a == -128 && b == -1) begin
                    m_fin_q = 8'h80; m_fin_r = 8'h00;
                end else begin
                    m_fin_q = 8'(a / b); m_fin_r = 8'(a % b);
                end
                m_busy_left = W + 1;
`else
                a = m_q; b = Din;
                m_fin_q = 8'(a / b); m_fin_r = 8'(a % b);
                m_busy_left = W;
`endif
            end
        end
        m_run_p  = m_run_s;
        m_run_s  = !Run_h;
        m_load_s = !ClearA_LoadB_h;
    endtask

    always @(posedge Clk) begin
        model_step();
        #1;
        chk("busy", Busy, m_busy_left > 0);
        chk("done", Done, m_done);
        chk("divzero", DivZero, m_dz);
        if (m_busy_left == 0) begin
            chk("qval", QVal, m_q);
            chk("rval", RVal, m_r);
        end
    end

    task automatic do_load(input logic [W-1:0] v);
        @(negedge Clk);
        Din = v; ClearA_LoadB_h = 1'b0;
        @(negedge Clk);
        ClearA_LoadB_h = 1'b1;
        @(negedge Clk);
    endtask

    // Press Run with divisor v for 'hold' cycles; optionally pulse load at cycle 'disturb'
    task automatic run_op(input logic [W-1:0] v, input int hold, input int disturb, output int lat);
        lat = 0;
        @(negedge Clk);
        Din = v; Run_h = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge Clk);
            if (k == hold) Run_h = 1'b1;
            if (k == disturb) begin Din = 8'h33; ClearA_LoadB_h = 1'b0; end
            if (k == disturb + 1) ClearA_LoadB_h = 1'b1;
            if (lat == 0 && k >= 2 && Done) lat = k;
            if (lat != 0 && k > hold && k > disturb + 1) break;
        end
        Run_h = 1'b1; ClearA_LoadB_h = 1'b1;
        if (lat == 0) chk("op_timeout", 0, 1);
    endtask

    task automatic div_case(input string nm, input logic [7:0] dvd, input logic [7:0] dvs,
                            input logic [7:0] eq, input logic [7:0] er, input int elat);
        int lat;
        do_load(dvd);
        run_op(dvs, 1, 0, lat);
        chk({nm, "_q"}, QVal, eq);
        chk({nm, "_r"}, RVal, er);
        chk({nm, "_lat"}, lat, elat);
    endtask

    initial begin
        int lat;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_q", QVal, 8'h00);
        chk("rst_r", RVal, 8'h00);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_dz", DivZero, 0);
        chk("rst_hex0", HEX0, 7'b1000000);
        chk("rst_hex2", HEX2, 7'b1000000);
        chk("rst_hex3", HEX3, 7'b1000000);
        Reset_n = 1'b1;
        @(negedge Clk);

        div_case("d100_7", 8'h64, 8'h07, 8'h0E, 8'h02, LAT);
        chk("d100_7_done", Done, 1);
        chk("d100_7_hex0", HEX0, 7'b0000110);
        div_case("d5_9", 8'h05, 8'h09, 8'h00, 8'h05, LAT);
        div_case("dff_1", 8'hFF, 8'h01, 8'hFF, 8'h00, LAT);
        div_case("dff_ff", 8'hFF, 8'hFF, 8'h01, 8'h00, LAT);
        div_case("div0", 8'h64, 8'h00, 8'hFF, 8'h64, 2);
        chk("div0_dz", DivZero, 1);
        chk("div0_hex4", HEX4, 7'b1111001);
`ifdef SIGNED_DIV_EN
        div_case("s_m100_7", 8'h9C, 8'h07, 8'hF2, 8'hFE, LAT);
        div_case("s_min_m1", 8'h80, 8'hFF, 8'h80, 8'h00, LAT);
`endif

        do_load(8'h64);
        run_op(8'h07, 50, 0, lat);
        chk("hold50_q", QVal, 8'h0E);
        chk("hold50_r", RVal, 8'h02);

        do_load(8'h64);
        run_op(8'h07, 1, 4, lat);
        chk("ldbusy_q", QVal, 8'h0E);
        chk("ldbusy_r", RVal, 8'h02);
        chk("ldbusy_lat", lat, LAT);

        do_load(8'hC8);
        @(negedge Clk);
        Din = 8'h0A; Run_h = 1'b0;
        repeat (6) @(negedge Clk);
        chk("midrun_busy", Busy, 1);
        Reset_n = 1'b0; Run_h = 1'b1;
        @(negedge Clk);
        Reset_n = 1'b1;
        chk("midrst_q", QVal, 8'h00);
        chk("midrst_r", RVal, 8'h00);
        chk("midrst_busy", Busy, 0);
        chk("midrst_done", Done, 0);
        repeat (3) @(negedge Clk);
        chk("midrst_idle", Busy, 0);

        Din = 8'h2A; Run_h = 1'b0; ClearA_LoadB_h = 1'b0;
        @(negedge Clk);
        Run_h = 1'b1; ClearA_LoadB_h = 1'b1;
        repeat (3) @(negedge Clk);
        chk("both_q", QVal, 8'h2A);
        chk("both_r", RVal, 8'h00);
        chk("both_busy", Busy, 0);
        chk("both_done", Done, 0);

        run_op(8'h05, 1, 0, lat);
        chk("after_both_q", QVal, 8'h08);
        chk("after_both_r", RVal, 8'h02);

        repeat (3) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
